// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage IF/ID/EX/MEM/WB pipe.
// Ports:
//   clock, reset        - system clock; synchronous active-high reset
//   enable              - start request, sampled while idle
//   id_ir, ex_ir, wb_ir - instructions in ID, EX and WB (opcode in [15:11])
//   branch_taken        - taken control transfer resolved in MEM
//   imem_ready          - I-cache ready (0 = miss in progress)
//   dmem_req/dmem_ready - D-cache access in MEM and its completion
//   state               - 1 = stages advance, 0 = stages hold (registered)
//   pc_hold, ex_bubble  - load-use stall controls (combinational)
//   flush               - squash IF/ID and ID/EX on taken branch (combinational)
//   running             - sequencer is in RUN or MISS_WAIT
//   miss_timeout        - sticky watchdog flag for over-long cache misses
//   stall_cnt, flush_cnt, miss_cnt - saturating event counters
module pipe_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MISS_MAX = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [15:0]      id_ir,
    input  logic [15:0]      ex_ir,
    input  logic [15:0]      wb_ir,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             state,
    output logic             pc_hold,
    output logic             ex_bubble,
    output logic             flush,
    output logic             running,
    output logic             miss_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int unsigned WaitW = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

    localparam logic [4:0] OpHalt = 5'b00001;
    localparam logic [4:0] OpLoad = 5'b00010;

    typedef enum logic [1:0] {StIdle, StRun, StMissWait, StHalted} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic             state_q, state_d;
    logic             timeout_q, timeout_d;
    logic [WaitW-1:0] wait_q, wait_d, wait_inc;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [4:0] id_op;
    logic [2:0] ex_rd;
    logic       rd_a, rd_b, rd_c;  // ID reads ir[6:4], ir[2:0], ir[10:8]
    logic       load_use, in_run, miss;

    assign id_op = id_ir[15:11];
    assign ex_rd = ex_ir[10:8];

    // Source-register usage of the instruction sitting in ID.
    always_comb begin
        rd_a = 1'b0;
        rd_b = 1'b0;
        rd_c = 1'b0;
        case (id_op)
            5'b00010:                             rd_a = 1'b1;  // LOAD
            5'b00011:                  begin rd_a = 1'b1; rd_c = 1'b1; end  // STORE
            5'b01000, 5'b10001, 5'b01010, 5'b10010,
            5'b01100, 5'b01101, 5'b01110, 5'b01111:
                                       begin rd_a = 1'b1; rd_b = 1'b1; end  // ALU reg-reg
            5'b00100, 5'b00101, 5'b00110, 5'b00111: rd_a = 1'b1;  // shifts
            5'b01001, 5'b01011, 5'b10000, 5'b11001,
            5'b11010, 5'b11011, 5'b11100, 5'b11101,
            5'b11110, 5'b11111:                   rd_c = 1'b1;  // imm ops, JMPR, branches
            default: ;
        endcase
    end

    assign load_use = (ex_ir[15:11] == OpLoad) &&
                      ((rd_a && (id_ir[6:4] == ex_rd)) ||
                       (rd_b && (id_ir[2:0] == ex_rd)) ||
                       (rd_c && (id_ir[10:8] == ex_rd)));

    assign in_run = (fsm_q == StRun);
    assign miss   = !imem_ready || (dmem_req && !dmem_ready);

    // A taken branch squashes the stalled instruction anyway, so it overrides the bubble.
    assign flush     = in_run && branch_taken;
    assign pc_hold   = in_run && load_use && !branch_taken;
    assign ex_bubble = pc_hold;

    assign wait_inc = (wait_q == WaitW'(MISS_MAX)) ? wait_q : wait_q + WaitW'(1);

    always_comb begin
        fsm_d       = fsm_q;
        timeout_d   = timeout_q;
        wait_d      = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        unique case (fsm_q)
            StIdle: begin
                if (enable) fsm_d = StRun;
            end
            StRun: begin
                if (pc_hold && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
                if (flush && flush_cnt_q != '1)   flush_cnt_d = flush_cnt_q + CNT_W'(1);
                if (miss) begin
                    fsm_d = StMissWait;
                end else if (wb_ir[15:11] == OpHalt) begin
                    fsm_d = StHalted;
                end
            end
            StMissWait: begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                if (wait_inc == WaitW'(MISS_MAX)) timeout_d = 1'b1;
                if (miss) begin
                    wait_d = wait_inc;
                end else begin
                    fsm_d = StRun;
                end
            end
            StHalted: ;
            default: fsm_d = StIdle;
        endcase

        state_d = (fsm_d == StRun);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q       <= StIdle;
            state_q     <= 1'b0;
            timeout_q   <= 1'b0;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            timeout_q   <= timeout_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign state        = state_q;
    assign running      = (fsm_q == StRun) || (fsm_q == StMissWait);
    assign miss_timeout = timeout_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the sequencer.
module tb_pipe_ctrl;

    localparam int CW = 4;
    localparam int MM = 3;
    localparam int SAT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset, enable, branch_taken, imem_ready, dmem_req, dmem_ready;
    logic [15:0]   id_ir, ex_ir, wb_ir;
    logic          state, pc_hold, ex_bubble, flush, running, miss_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt, miss_cnt;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 run, 2 waiting on a miss, 3 halted.
    int m_mode, m_wait, m_stall, m_flush, m_miss;
    bit m_state, m_tmo;

    pipe_ctrl #(.CNT_W(CW), .MISS_MAX(MM)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .id_ir(id_ir), .ex_ir(ex_ir), .wb_ir(wb_ir),
        .branch_taken(branch_taken), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .state(state), .pc_hold(pc_hold), .ex_bubble(ex_bubble), .flush(flush),
        .running(running), .miss_timeout(miss_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clock = ~clock;

    // Which source fields an opcode reads: 0 = ir[6:4], 1 = ir[2:0], 2 = ir[10:8].
    function automatic bit reads(input logic [4:0] op, input int field);
        case (field)
            0: return op inside {5'b00010, 5'b00011, 5'b01000, 5'b10001, 5'b01010, 5'b10010,
                                 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b00100, 5'b00101,
                                 5'b00110, 5'b00111};
            1: return op inside {5'b01000, 5'b10001, 5'b01010, 5'b10010, 5'b01100, 5'b01101,
                                 5'b01110, 5'b01111};
            default: return op inside {5'b00011, 5'b01001, 5'b01011, 5'b10000, 5'b11001,
                                       5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b11110,
                                       5'b11111};
        endcase
    endfunction

    function automatic bit model_hazard();
        logic [2:0] rd;
        logic [4:0] op;
        if (m_mode != 1 || ex_ir[15:11] != 5'b00010) return 1'b0;
        rd = ex_ir[10:8];
        op = id_ir[15:11];
        return (reads(op, 0) && id_ir[6:4] == rd) || (reads(op, 1) && id_ir[2:0] == rd) ||
               (reads(op, 2) && id_ir[10:8] == rd);
    endfunction

    function automatic bit model_flush();
        return (m_mode == 1) && branch_taken;
    endfunction

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        bit hz, fl, ms, rst, en, hlt;
        int nm, inc;
        hz  = model_hazard() && !model_flush();
        fl  = model_flush();
        ms  = !imem_ready || (dmem_req && !dmem_ready);
        rst = reset;
        en  = enable;
        hlt = (wb_ir[15:11] == 5'b00001);
        @(posedge clock);
        if (rst) begin
            m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_miss = 0;
            m_state = 0; m_tmo = 0;
        end else begin
            nm = m_mode;
            case (m_mode)
                0: if (en) nm = 1;
                1: begin
                    if (hz) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
                    if (fl) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
                    m_wait = 0;
                    if (ms) nm = 2;
                    else if (hlt) nm = 3;
                end
                2: begin
                    m_miss = (m_miss < SAT) ? m_miss + 1 : SAT;
                    inc = (m_wait + 1 > MM) ? MM : m_wait + 1;
                    if (inc == MM) m_tmo = 1;
                    if (ms) m_wait = inc;
                    else begin m_wait = 0; nm = 1; end
                end
                default: ;
            endcase
            m_mode  = nm;
            m_state = (nm == 1);
        end
        #1;
    endtask

    task automatic quiet_inputs();
        enable = 0; id_ir = 0; ex_ir = 0; wb_ir = 0; branch_taken = 0;
        imem_ready = 1; dmem_req = 0; dmem_ready = 1;
    endtask

    task automatic go_run();
        quiet_inputs();
        reset = 1;
        tick();
        reset = 0;
        enable = 1;
        tick();
        enable = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        enable = 1; id_ir = 16'h4132; ex_ir = 16'h1300; wb_ir = 16'h0800;
        branch_taken = 1; imem_ready = 0; dmem_req = 1; dmem_ready = 0;
        tick();
        tick();
        quiet_inputs();
        #1;
        checks++;
        if ({state, running, miss_timeout, pc_hold, ex_bubble, flush} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {state, running, miss_timeout, pc_hold, ex_bubble, flush});
        end
        checks++;
        if ({stall_cnt, flush_cnt, miss_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_counters got=%h/%h/%h exp=0/0/0", stall_cnt, flush_cnt, miss_cnt);
        end
        reset = 0;
        enable = 1;
        #1;
        checks++;
        if (state !== 1'b0) begin
            failures++;
            $display("FAIL enable_same_cycle got=%b exp=0", state);
        end
        tick();
        enable = 0;
        checks++;
        if (state !== 1'b1 || running !== 1'b1) begin
            failures++;
            $display("FAIL enable_next_cycle got=%b%b exp=11", state, running);
        end
    endtask

    task automatic test_load_use();
        go_run();
        ex_ir = 16'h1300;
        id_ir = 16'h4132;
        #1;
        checks++;
        if ({pc_hold, ex_bubble, flush} !== 3'b110) begin
            failures++;
            $display("FAIL load_use_ctrl got=%b exp=110", {pc_hold, ex_bubble, flush});
        end
        tick();
        ex_ir = 16'h0000;  // bubble now in EX
        #1;
        checks++;
        if (pc_hold !== 1'b0 || stall_cnt !== CW'(1)) begin
            failures++;
            $display("FAIL load_use_after got=%b/%0d exp=0/1", pc_hold, stall_cnt);
        end
        // NOP in ID with matching register bits never stalls.
        ex_ir = 16'h1300;
        id_ir = 16'h0333;
        #1;
        checks++;
        if (pc_hold !== 1'b0) begin
            failures++;
            $display("FAIL nop_no_hazard got=%b exp=0", pc_hold);
        end
        // gr0 dependency through ir[10:8] (ADDI gr0 after LOAD gr0).
        ex_ir = 16'h1000;
        id_ir = 16'h4807;
        #1;
        checks++;
        if (pc_hold !== 1'b1) begin
            failures++;
            $display("FAIL gr0_hazard got=%b exp=1", pc_hold);
        end
        tick();
    endtask

    task automatic test_flush_priority();
        go_run();
        ex_ir = 16'h1300;
        id_ir = 16'h4132;
        branch_taken = 1;
        #1;
        checks++;
        if ({pc_hold, ex_bubble, flush} !== 3'b001) begin
            failures++;
            $display("FAIL flush_priority got=%b exp=001", {pc_hold, ex_bubble, flush});
        end
        tick();
        quiet_inputs();
        #1;
        checks++;
        if (flush_cnt !== CW'(1) || stall_cnt !== CW'(0)) begin
            failures++;
            $display("FAIL flush_counts got=%0d/%0d exp=1/0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_dmem_miss();
        go_run();
        dmem_req = 1;
        dmem_ready = 0;
        #1;
        checks++;
        if (state !== 1'b1) begin
            failures++;
            $display("FAIL miss_start got=%b exp=1", state);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (state !== 1'b0 || pc_hold !== 1'b0 || flush !== 1'b0) begin
                failures++;
                $display("FAIL miss_frozen cyc=%0d got=%b%b%b exp=000", i, state, pc_hold, flush);
            end
        end
        dmem_req = 0;
        dmem_ready = 1;
        tick();
        checks++;
        if (state !== 1'b1 || miss_cnt !== CW'(4)) begin
            failures++;
            $display("FAIL miss_resume got=%b/%0d exp=1/4", state, miss_cnt);
        end
    endtask

    task automatic test_timeout();
        go_run();
        imem_ready = 0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (miss_timeout !== 1'b1 || running !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set got=%b/%b exp=1/1", miss_timeout, running);
        end
        imem_ready = 1;
        tick();
        tick();
        checks++;
        if (miss_timeout !== 1'b1 || state !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b/%b exp=1/1", miss_timeout, state);
        end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (miss_timeout !== 1'b0 || running !== 1'b0 || state !== 1'b0) begin
            failures++;
            $display("FAIL timeout_reset got=%b%b%b exp=000", miss_timeout, running, state);
        end
    endtask

    task automatic test_halt();
        go_run();
        wb_ir = 16'h0800;
        tick();
        wb_ir = 16'h0000;
        enable = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (state !== 1'b0 || running !== 1'b0) begin
                failures++;
                $display("FAIL halted cyc=%0d got=%b%b exp=00", i, state, running);
            end
        end
        reset = 1;
        tick();
        reset = 0;
        enable = 1;
        tick();
        enable = 0;
        checks++;
        if (state !== 1'b1) begin
            failures++;
            $display("FAIL halt_restart got=%b exp=1", state);
        end
    endtask

    task automatic test_random();
        bit e_hz, e_fl;
        quiet_inputs();
        reset = 1;
        tick();
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 199) == 0);
            enable       = ($urandom_range(0, 3) != 0);
            id_ir        = 16'($urandom);
            ex_ir        = $urandom_range(0, 1) ? {5'b00010, 11'($urandom)} : 16'($urandom);
            wb_ir        = 16'($urandom);
            if (wb_ir[15:11] == 5'b00001) wb_ir[15:11] = 5'b01000;
            if ($urandom_range(0, 99) == 0) wb_ir[15:11] = 5'b00001;
            branch_taken = ($urandom_range(0, 5) == 0);
            imem_ready   = ($urandom_range(0, 7) != 0);
            dmem_req     = $urandom_range(0, 1);
            dmem_ready   = ($urandom_range(0, 3) != 0);
            #1;
            e_hz = model_hazard() && !model_flush();
            e_fl = model_flush();
            checks++;
            if ({pc_hold, ex_bubble, flush} !== {e_hz, e_hz, e_fl}) begin
                failures++;
                $display("FAIL rnd_ctrl n=%0d got=%b exp=%b", n, {pc_hold, ex_bubble, flush},
                         {e_hz, e_hz, e_fl});
            end
            checks++;
            if ({state, running, miss_timeout} !==
                {m_state, (m_mode == 1 || m_mode == 2), m_tmo}) begin
                failures++;
                $display("FAIL rnd_status n=%0d got=%b exp=%b", n, {state, running, miss_timeout},
                         {m_state, (m_mode == 1 || m_mode == 2), m_tmo});
            end
            checks++;
            if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush) ||
                miss_cnt !== CW'(m_miss)) begin
                failures++;
                $display("FAIL rnd_counters n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n,
                         stall_cnt, flush_cnt, miss_cnt, m_stall, m_flush, m_miss);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        go_run();
        ex_ir = 16'h1300;
        id_ir = 16'h4132;
        for (int i = 0; i < SAT + 5; i++) tick();
        ex_ir = 16'h0000;
        #1;
        checks++;
        if (stall_cnt !== CW'(SAT)) begin
            failures++;
            $display("FAIL stall_saturate got=%0d exp=%0d", stall_cnt, SAT);
        end
    endtask

    initial begin
        quiet_inputs();
        reset = 1;
        m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_miss = 0; m_state = 0; m_tmo = 0;
        test_reset();
        test_load_use();
        test_flush_priority();
        test_dmem_miss();
        test_timeout();
        test_halt();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
